// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column strobe, frame-level debounce, hex key output.
// Accept latency is DEBOUNCE_SCANS frames plus one cycle; no backpressure, KEY_VALID is a one-cycle pulse.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] KEY,
  output logic       KEY_VALID,
  output logic       KEY_HELD
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_N    = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  logic [3:0]       r_sync1, r_sync2;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col_idx;
  logic [3:0]       r_col;
  logic             r_acc_any, r_acc_multi;
  logic [3:0]       r_acc_code;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_cand;
  logic [3:0]       r_key;
  logic             r_valid, r_held;

  logic       w_tc;
  logic [3:0] w_rows;
  logic       w_col_any, w_col_multi;
  logic [1:0] w_row_idx;
  logic [3:0] w_col_code;
  logic       w_f_any, w_f_multi, w_f_single;
  logic [3:0] w_f_code;
  logic [CNT_W-1:0] w_cnt_inc;

  function automatic logic [3:0] key_code(input logic [1:0] c, input logic [1:0] r);
    case ({c, r})
      4'b00_00: key_code = 4'h1;  4'b00_01: key_code = 4'h4;
      4'b00_10: key_code = 4'h7;  4'b00_11: key_code = 4'h0;
      4'b01_00: key_code = 4'h2;  4'b01_01: key_code = 4'h5;
      4'b01_10: key_code = 4'h8;  4'b01_11: key_code = 4'hF;
      4'b10_00: key_code = 4'h3;  4'b10_01: key_code = 4'h6;
      4'b10_10: key_code = 4'h9;  4'b10_11: key_code = 4'hE;
      4'b11_00: key_code = 4'hA;  4'b11_01: key_code = 4'hB;
      4'b11_10: key_code = 4'hC;  default:  key_code = 4'hD;
    endcase
  endfunction

  assign w_tc        = (r_div == DIV_LAST);
  assign w_rows      = ~r_sync2;
  assign w_col_any   = |w_rows;
  assign w_col_multi = ((w_rows & (w_rows - 4'd1)) != 4'd0);
  assign w_cnt_inc   = r_cnt + CNT_ONE;

  always_comb begin
    w_row_idx = 2'd0;
    if      (w_rows[0]) w_row_idx = 2'd0;
    else if (w_rows[1]) w_row_idx = 2'd1;
    else if (w_rows[2]) w_row_idx = 2'd2;
    else if (w_rows[3]) w_row_idx = 2'd3;
  end

  assign w_col_code = key_code(r_col_idx, w_row_idx);

  // A key seen in two different columns also makes the frame ambiguous.
  assign w_f_any    = r_acc_any | w_col_any;
  assign w_f_multi  = r_acc_multi | w_col_multi | (r_acc_any & w_col_any);
  assign w_f_single = w_f_any & ~w_f_multi;
  assign w_f_code   = w_col_any ? w_col_code : r_acc_code;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1     <= 4'hF;
      r_sync2     <= 4'hF;
      r_div       <= '0;
      r_col_idx   <= 2'd0;
      r_col       <= 4'b1110;
      r_acc_any   <= 1'b0;
      r_acc_multi <= 1'b0;
      r_acc_code  <= 4'h0;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cand      <= 4'h0;
      r_key       <= 4'h0;
      r_valid     <= 1'b0;
      r_held      <= 1'b0;
    end else begin
      r_sync1 <= ROW;
      r_sync2 <= r_sync1;
      r_valid <= 1'b0;
      r_div   <= w_tc ? '0 : r_div + 1'b1;
      if (w_tc) begin
        r_col_idx <= r_col_idx + 2'd1;
        r_col     <= {r_col[2:0], r_col[3]};
        if (r_col_idx != 2'd3) begin
          r_acc_any   <= w_f_any;
          r_acc_multi <= w_f_multi;
          r_acc_code  <= w_f_code;
        end else begin
          r_acc_any   <= 1'b0;
          r_acc_multi <= 1'b0;
          r_acc_code  <= 4'h0;
          case (r_state)
            IDLE: if (w_f_single) begin
              r_cand <= w_f_code;
              if (DEBOUNCE_SCANS == 1) begin
                r_state <= PRESSED;
                r_key   <= w_f_code;
                r_valid <= 1'b1;
                r_held  <= 1'b1;
              end else begin
                r_state <= DEBOUNCE;
                r_cnt   <= CNT_ONE;
              end
            end
            DEBOUNCE: begin
              if (!w_f_single) begin
                r_state <= IDLE;
                r_cnt   <= '0;
              end else if (w_f_code != r_cand) begin
                r_cand <= w_f_code;
                r_cnt  <= CNT_ONE;
              end else if (w_cnt_inc == DEB_N) begin
                r_state <= PRESSED;
                r_cnt   <= '0;
                r_key   <= r_cand;
                r_valid <= 1'b1;
                r_held  <= 1'b1;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end
            PRESSED: if (!w_f_any) begin
              if (DEBOUNCE_SCANS == 1) begin
                r_state <= IDLE;
                r_held  <= 1'b0;
              end else begin
                r_state <= RELEASE;
                r_cnt   <= CNT_ONE;
              end
            end
            default: begin
              if (w_f_any) begin
                r_state <= PRESSED;
                r_cnt   <= '0;
              end else if (w_cnt_inc == DEB_N) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_held  <= 1'b0;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end
          endcase
        end
      end
    end
  end

  assign COL       = r_col;
  assign KEY       = r_key;
  assign KEY_VALID = r_valid;
  assign KEY_HELD  = r_held;

endmodule
